// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder/subtractor.
// The operation state is exported so checkers and benches can observe it directly.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of compute cycles needed to cover the full operand width.
  function automatic int nsteps(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit params_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand/result bundle for the chunked serial adder.
// Handshake: a bundle transfers on a rising edge where valid and ready are both high;
// the producer holds valid and its payload stable until that edge, and ready may
// depend combinationally on the downstream ready but never on valid.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             subtract;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carryin, subtract, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carryin, subtract, out_ready,
    output in_ready, out_valid, sum, carryout, overflow, zero
  );

endinterface

// File: rtl/chunked_serial_adder_adder_chunk.sv
// CHUNK-bit ripple-carry slice; also exposes the carry into its MSB so the
// caller can derive two's-complement overflow on the top chunk.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// WIDTH-bit adder/subtractor that adds CHUNK bits per clock, carrying between
// cycles through a register, behind valid/ready handshakes on both sides.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  chunked_serial_adder_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int NSTEPS = nsteps(WIDTH, CHUNK);
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_cmsb;
  logic [WIDTH-1:0] sum_next;
  logic             accept;
  int               off;

  // The slice operates on the chunk selected by the step counter; sum_next is
  // the running sum with this cycle's chunk merged in, used for the zero flag.
  always_comb begin
    off      = int'(cnt) * CHUNK;
    ch_a     = a_r[off +: CHUNK];
    ch_b     = b_r[off +: CHUNK];
    sum_next = sum_r;
    sum_next[off +: CHUNK] = ch_sum;
  end

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (ch_a),
    .b        (ch_b),
    .cin      (carry),
    .sum      (ch_sum),
    .cout     (ch_cout),
    .c_msb_in (ch_cmsb)
  );

  // In DONE the consumer's ready passes through so a new operand bundle can be
  // taken on the same edge that the current result leaves.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.carryout  = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
  assign dbg_state     = state;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Subtraction is a + ~b + ~borrow, so the datapath only ever adds.
            a_r   <= bus.a;
            b_r   <= bus.subtract ? ~bus.b : bus.b;
            carry <= bus.subtract ? ~bus.carryin : bus.carryin;
            cnt   <= '0;
            state <= RUN;
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= ch_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_r <= ch_cout;
            ovf_r  <= ch_cmsb ^ ch_cout;
            zero_r <= (sum_next == '0);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: a CHUNK=8 and a CHUNK=32 instance driven with
// directed and random operand bundles, results scored against an arithmetic model.
module tb_chunked_serial_adder;
  import chunked_serial_adder_pkg::*;

  localparam int W    = 32;
  localparam int EW   = W + 3;
  localparam int NS8  = W / 8;
  localparam int NS32 = 1;

  logic clk;
  logic reset;

  chunked_serial_adder_if #(.WIDTH(W)) bus8 ();
  chunked_serial_adder_if #(.WIDTH(W)) bus32 ();
  state_t dbg8;
  state_t dbg32;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_ci;
  logic         op_sub;
  logic         iv[2];
  logic         ordy[2];
  bit           rnd_on;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  int n_checks;
  int n_pass;

  assign bus8.in_valid   = iv[0];
  assign bus8.out_ready  = ordy[0];
  assign bus8.a          = op_a;
  assign bus8.b          = op_b;
  assign bus8.carryin    = op_ci;
  assign bus8.subtract   = op_sub;
  assign bus32.in_valid  = iv[1];
  assign bus32.out_ready = ordy[1];
  assign bus32.a         = op_a;
  assign bus32.b         = op_b;
  assign bus32.carryin   = op_ci;
  assign bus32.subtract  = op_sub;

  chunked_serial_adder #(.WIDTH(W), .CHUNK(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus8),
    .dbg_state (dbg8)
  );

  chunked_serial_adder #(.WIDTH(W), .CHUNK(32)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus32),
    .dbg_state (dbg32)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Result layout: {sum, carryout, overflow, zero}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic ci, input logic sb);
    longint ua, ub, sa, sbv, ru, rs;
    logic [W-1:0] s;
    logic cout, ovf;
    ua  = longint'({32'd0, xa});
    ub  = longint'({32'd0, xb});
    sa  = longint'($signed(xa));
    sbv = longint'($signed(xb));
    if (!sb) begin
      ru   = ua + ub + longint'(ci);
      rs   = sa + sbv + longint'(ci);
      cout = (ru >= 64'sh1_0000_0000);
    end else begin
      ru   = ua - ub - longint'(ci);
      rs   = sa - sbv - longint'(ci);
      cout = (ru >= 0);
    end
    ovf = (rs > 64'sh7FFF_FFFF) || (rs < -64'sh8000_0000);
    s   = ru[W-1:0];
    return {s, cout, ovf, (s == '0)};
  endfunction

  function automatic logic rd_in_ready(input int d);
    return (d == 0) ? bus8.in_ready : bus32.in_ready;
  endfunction

  function automatic logic rd_out_valid(input int d);
    return (d == 0) ? bus8.out_valid : bus32.out_valid;
  endfunction

  function automatic logic [EW-1:0] rd_result(input int d);
    if (d == 0) return {bus8.sum, bus8.carryout, bus8.overflow, bus8.zero};
    return {bus32.sum, bus32.carryout, bus32.overflow, bus32.zero};
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset && rd_out_valid(d) && ordy[d]) begin
          if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_checks++;
            $display("FAIL spurious_result_dut%0d: got 0x%0h, expected no result", d, rd_result(d));
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check((d == 0) ? "result_c8" : "result_c32", 64'(rd_result(d)), 64'(e));
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) ordy[0] = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at 1 time unit after a rising edge.
  task automatic do_op(input int d, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic ci, input logic sb, input bit push);
    int n;
    op_a = xa; op_b = xb; op_ci = ci; op_sub = sb;
    iv[d] = 1'b1;
    if (push) begin
      if (d == 0) exp_q0.push_back(model(xa, xb, ci, sb));
      else        exp_q1.push_back(model(xa, xb, ci, sb));
    end
    n = 0;
    @(negedge clk);
    while (!rd_in_ready(d) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout_dut%0d: got in_ready=0 for 200 cycles, expected 1", d);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  // Counts cycles with out_valid low after acceptance.
  task automatic wait_latency(input int d, input int expected, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!rd_out_valid(d) && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(expected));
    @(posedge clk);
    #1;
  endtask

  task automatic dir_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic ci, input logic sb);
    do_op(0, xa, xb, ci, sb, 1'b1);
    wait_latency(0, NS8, "latency_c8");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] hold_exp;
    int seen;
    int n;
    reset = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    op_a = '0; op_b = '0; op_ci = 1'b0; op_sub = 1'b0;
    rnd_on = 1'b0;
    n_checks = 0;
    n_pass = 0;
    fork
      monitor();
      ready_driver();
      begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state_c8", 64'({bus8.in_ready, bus8.out_valid, rd_result(0)}), 64'({2'b10, 35'd0}));
    check("reset_state_c32", 64'({bus32.in_ready, bus32.out_valid, rd_result(1)}), 64'({2'b10, 35'd0}));
    @(posedge clk);
    #1;

    // Directed arithmetic corners.
    dir_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    dir_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    dir_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    dir_op(32'd5, 32'd7, 1'b0, 1'b1);
    dir_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    dir_op(32'd10, 32'd3, 1'b1, 1'b1);

    // Backpressure: result held for 5 cycles, then consumed alongside a new accept.
    ordy[0] = 1'b0;
    hold_exp = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
    wait_latency(0, NS8, "latency_bp");
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 64'(bus8.out_valid), 64'd1);
      check("hold_result", 64'(rd_result(0)), 64'(hold_exp));
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    do_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    wait_latency(0, NS8, "latency_passthru");

    // Reset while computing chunk 2: that operation must never produce a result.
    do_op(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(bus8.in_ready), 64'd1);
    seen = 0;
    repeat (NS8 + 4) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    dir_op(32'd1, 32'd1, 1'b0, 1'b0);

    // Random operations under random consumer backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_op(0, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rnd_on = 1'b0;
    ordy[0] = 1'b1;

    // Single-step instance: result appears the cycle after acceptance.
    do_op(1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    wait_latency(1, NS32, "latency_c32");
    for (int i = 0; i < 12; i++) begin
      do_op(1, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_latency(1, NS32, "latency_c32_rnd");
    end

    n = 0;
    while (((exp_q0.size() + exp_q1.size()) != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised WIDTH-bit adder/subtractor that processes CHUNK bits per clock and ripples the carry between cycles through a registered carry.
- Trades latency for a short carry chain.
- Wrapped in a valid/ready handshake on input and output so it sits directly on the datapath between operand registers and the result/flag consumer.
- Produces sum, carryout, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NSTEPS (localparam), WIDTH/CHUNK, number of compute cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle present.
- in_ready  output  1  block can accept an operand bundle this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- carryin  input  1  carry-in (add) or borrow-in (subtract).
- subtract  input  1  0: a+b+carryin; 1: a-b-carryin.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carryout  output  1  final carry out of MSB; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset, all synchronous: state IDLE, step counter 0, in_ready 1, out_valid 0, sum 0, carryout 0, overflow 0, zero 0. Reset has priority over every other event.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at the edge (accept):
  - latch a.
  - latch b_eff = subtract ? ~b : b.
  - latch carry = subtract ? ~carryin : carryin.
  - counter=0; go to RUN.
- RUN: in_ready=0; in_valid is ignored and not stored.
  - Each edge computes chunk k = counter: {c, sum[k*CHUNK +: CHUNK]} = a_chunk + b_eff_chunk + carry; carry <= c; counter++.
  - On the edge computing k = NSTEPS-1:
    - carryout <= final carry.
    - overflow <= carry into MSB XOR carry out of MSB.
    - zero <= (full sum == 0).
    - go to DONE.
- Latency: with acceptance at edge E0, out_valid is high in the cycle after edge E(NSTEPS). With CHUNK = WIDTH, the result is valid one cycle after acceptance.
- DONE: out_valid=1.
  - sum and the flags are held stable while out_ready=0, for any number of cycles.
  - in_ready = out_ready (pass-through acceptance).
  - On out_ready=1 and in_valid=0: go to IDLE; out_valid 0 next cycle.
  - On out_ready=1 and in_valid=1 in the same cycle: the result is consumed and new operands are accepted at the same edge; go to RUN; out_valid 0 next cycle. No bubble beyond the NSTEPS compute cycles.
- sum is undefined to observers while out_valid=0; only out_valid qualifies sum and the flags.
- Reset in RUN or DONE: the operation is aborted and no result is emitted. The next cycle is IDLE with in_ready=1.
- Arithmetic is unsigned modulo 2^WIDTH. overflow is computed as if the operands are signed two's-complement. Both flags are always computed regardless of mode.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, RUN, DONE).
  - Localparam helper for NSTEPS.
  - Elaboration check that WIDTH % CHUNK == 0 and CHUNK >= 1.
- One sub-module: adder_chunk.
  - Parametrised CHUNK-bit ripple-carry slice.
  - Ports: a, b, cin; outputs sum, cout, and carry into the MSB (c_msb_in) for overflow.
  - Instantiated once and reused every cycle on the selected chunk.

Test Plan:
- WIDTH=32, CHUNK=8, add a=0x000000FF, b=0x00000001, cin=0 -> out_valid in cycle after 4th edge post-accept; sum=0x00000100, carryout=0, overflow=0, zero=0.
- Add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, carryout=1, zero=1, overflow=0.
- Add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1, carryout=0.
- Subtract:
  - a=5, b=7, cin=0 -> sum=0xFFFFFFFE, carryout=0 (borrow), overflow=0.
  - a=0x80000000, b=1 -> sum=0x7FFFFFFF, overflow=1, carryout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and sum/flags unchanged.
  - Then raise out_ready with in_valid=1 (a=3, b=4) -> accepted at the same edge, out_valid=0 next cycle, sum=7 after 4 more edges.
- Reset during RUN at counter=2 -> out_valid never rises for that op, in_ready=1 next cycle. Following add 1+1 -> sum=2. Repeat with CHUNK=32: 1+1 -> out_valid the cycle after acceptance.
